// File: rtl/crc16_calc.sv
`default_nettype none
// ============================================================================
// Module      : crc16_calc
// Description : Bit-serial CRC-16 accumulator. Each accepted byte is shifted
//               MSB first over eight clocks; the last byte of a message is
//               followed by a one-cycle crc_rdy while the final CRC is shown.
// Revision    : 1.0 - initial release
// ============================================================================
module crc16_calc #(
  parameter logic [15:0] POLY   = 16'h1021,
  parameter logic [15:0] INIT   = 16'hFFFF,
  parameter logic [15:0] XOROUT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  d,
  input  logic        d_rdy,
  input  logic        d_last,
  input  logic        crc_n_rst,
  output logic        busy,
  output logic [15:0] crc,
  output logic        crc_rdy,
  output logic        ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        last_q, last_d;
  logic        ovf_q, ovf_d;
  logic        fb;

  assign fb = acc_q[15] ^ sh_q[7];

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    last_d    = last_q;
    ovf_d     = ovf_q;

    // The sender's clear outranks everything, including a same-edge strobe.
    if (!crc_n_rst) begin
      state_d   = S_IDLE;
      acc_d     = INIT;
      bit_cnt_d = 3'd0;
      ovf_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (d_rdy) begin
            sh_d      = d;
            last_d    = d_last;
            bit_cnt_d = 3'd0;
            state_d   = S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc_d     = {acc_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
          sh_d      = {sh_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = last_q ? S_DONE : S_IDLE;
          end
          if (d_rdy) begin
            ovf_d = 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          if (d_rdy) begin
            ovf_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= INIT;
      sh_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      last_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign crc_rdy = (state_q == S_DONE);
  assign crc     = acc_q ^ XOROUT;
  assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_crc16_calc.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc16_calc
// Description : Randomised self-checking bench for crc16_calc against a
//               message-level CRC-16 reference computed by polynomial division.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc16_calc;

  localparam logic [15:0] C_POLY   = 16'h1021;
  localparam logic [15:0] C_INIT   = 16'hFFFF;
  localparam logic [15:0] C_XOROUT = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  d = 8'h00;
  logic        d_rdy = 1'b0;
  logic        d_last = 1'b0;
  logic        crc_n_rst = 1'b1;
  logic        busy;
  logic [15:0] crc;
  logic        crc_rdy;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;

  crc16_calc #(
    .POLY   (C_POLY),
    .INIT   (C_INIT),
    .XOROUT (C_XOROUT)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .d_rdy     (d_rdy),
    .d_last    (d_last),
    .crc_n_rst (crc_n_rst),
    .busy      (busy),
    .crc       (crc),
    .crc_rdy   (crc_rdy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Remainder of (message * x^16) mod G with the register preloaded to INIT.
  function automatic logic [15:0] crc_ref(input logic [7:0] msg[$]);
    logic [31:0] r;
    r = {16'h0000, C_INIT};
    foreach (msg[k]) begin
      r = r ^ ({24'h0, msg[k]} << 8);
      for (int j = 0; j < 8; j++) begin
        r = r << 1;
        if (r[16]) r = r ^ {15'h0, 1'b1, C_POLY};
        r = r & 32'h0000FFFF;
      end
    end
    return r[15:0] ^ C_XOROUT;
  endfunction

  // Waits (bounded) for idle at a falling edge, strobes one byte, returns one
  // falling edge after the accepting rising edge.
  task automatic accept(input logic [7:0] b, input logic last);
    int t = 0;
    while (busy !== 1'b0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout busy=%b required 0", busy);
    end
    d = b; d_last = last; d_rdy = 1'b1;
    @(negedge clk);
    d_rdy = 1'b0; d_last = 1'b0;
  endtask

  // Counts busy cycles and crc_rdy pulses until the block goes idle.
  task automatic run_out(output int bc, output int rp, output logic [15:0] cs);
    int t = 0;
    bc = 0; rp = 0; cs = 16'hxxxx;
    while (busy === 1'b1 && t < 40) begin
      bc++;
      if (crc_rdy === 1'b1) begin
        rp++;
        cs = crc;
      end
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      n_cmp++; n_err++;
      $display("FAIL run_out_timeout busy still %b after 40 cycles", busy);
    end
  endtask

  task automatic clear_pulse();
    crc_n_rst = 1'b0;
    @(negedge clk);
    crc_n_rst = 1'b1;
  endtask

  task automatic send_msg(input logic [7:0] msg[$], output int rp, output logic [15:0] cs);
    int bc, r;
    logic [15:0] c;
    rp = 0; cs = 16'hxxxx;
    foreach (msg[k]) begin
      accept(msg[k], (k == msg.size() - 1));
      run_out(bc, r, c);
      rp += r;
      if (r != 0) cs = c;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (crc !== (C_INIT ^ C_XOROUT)) begin n_err++; $display("FAIL reset_crc got %h want %h", crc, C_INIT ^ C_XOROUT); end
    n_cmp++; if (crc_rdy !== 1'b0) begin n_err++; $display("FAIL reset_crc_rdy got %b want 0", crc_rdy); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_zero();
    int bc, rp;
    logic [15:0] cs;
    accept(8'h00, 1'b1);
    run_out(bc, rp, cs);
    n_cmp++; if (bc != 9) begin n_err++; $display("FAIL zero_busy_cycles got %0d want 9", bc); end
    n_cmp++; if (rp != 1) begin n_err++; $display("FAIL zero_rdy_pulses got %0d want 1", rp); end
    n_cmp++; if (cs !== 16'hE1F0) begin n_err++; $display("FAIL zero_crc got %h want e1f0", cs); end
    n_cmp++; if (crc_rdy !== 1'b0) begin n_err++; $display("FAIL zero_rdy_after got %b want 0", crc_rdy); end
    clear_pulse();
    n_cmp++; if (crc !== 16'hFFFF) begin n_err++; $display("FAIL zero_clear_crc got %h want ffff", crc); end
  endtask

  task automatic test_check_string();
    int bc, rp;
    logic [15:0] cs;
    for (int k = 0; k < 9; k++) begin
      accept(8'h31 + 8'(k), (k == 8));
      run_out(bc, rp, cs);
      if (k < 8) begin
        n_cmp++; if (bc != 8 || rp != 0) begin n_err++; $display("FAIL str_byte%0d busy=%0d rdy=%0d want 8/0", k, bc, rp); end
      end else begin
        n_cmp++; if (bc != 9 || rp != 1) begin n_err++; $display("FAIL str_last busy=%0d rdy=%0d want 9/1", bc, rp); end
        n_cmp++; if (cs !== 16'h29B1) begin n_err++; $display("FAIL str_crc got %h want 29b1", cs); end
      end
    end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL str_ovf got %b want 0", ovf); end
    clear_pulse();
    n_cmp++; if (crc !== 16'hFFFF) begin n_err++; $display("FAIL str_clear_crc got %h want ffff", crc); end
  endtask

  task automatic test_random();
    logic [7:0] msg[$];
    logic [7:0] msg_b[$];
    logic [7:0] cat[$];
    int rp;
    logic [15:0] cs, exp;
    for (int it = 0; it < 6; it++) begin
      msg.delete();
      for (int k = 0; k < int'($urandom_range(1, 8)); k++) msg.push_back(8'($urandom));
      exp = crc_ref(msg);
      send_msg(msg, rp, cs);
      n_cmp++; if (rp != 1 || cs !== exp) begin n_err++; $display("FAIL rand%0d crc got %h (pulses %0d) want %h", it, cs, rp, exp); end
      clear_pulse();
    end
    // Back-to-back without a clear: result covers the concatenation.
    msg.delete(); msg_b.delete();
    for (int k = 0; k < 3; k++) msg.push_back(8'($urandom));
    for (int k = 0; k < 4; k++) msg_b.push_back(8'($urandom));
    cat = {msg, msg_b};
    send_msg(msg, rp, cs);
    n_cmp++; if (cs !== crc_ref(msg)) begin n_err++; $display("FAIL b2b_first got %h want %h", cs, crc_ref(msg)); end
    send_msg(msg_b, rp, cs);
    exp = crc_ref(cat);
    n_cmp++; if (cs !== exp) begin n_err++; $display("FAIL b2b_concat got %h want %h", cs, exp); end
    clear_pulse();
  endtask

  task automatic test_overflow();
    logic [7:0] msg[$];
    int bc, rp;
    logic [15:0] cs, exp;
    for (int k = 0; k < 3; k++) msg.push_back(8'($urandom));
    exp = crc_ref(msg);
    accept(msg[0], 1'b0);
    @(negedge clk);
    d = ~msg[0]; d_rdy = 1'b1;
    @(negedge clk);
    d_rdy = 1'b0;
    run_out(bc, rp, cs);
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", ovf); end
    accept(msg[1], 1'b0);
    run_out(bc, rp, cs);
    accept(msg[2], 1'b1);
    run_out(bc, rp, cs);
    n_cmp++; if (rp != 1 || cs !== exp) begin n_err++; $display("FAIL ovf_crc got %h (pulses %0d) want %h", cs, rp, exp); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    clear_pulse();
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", ovf); end
  endtask

  task automatic test_clear_mid_shift();
    logic [7:0] msg[$];
    int rp;
    logic [15:0] cs, exp;
    accept(8'($urandom), 1'b1);
    @(negedge clk);
    @(negedge clk);
    clear_pulse();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL clr_mid_busy got %b want 0", busy); end
    n_cmp++; if (crc !== 16'hFFFF) begin n_err++; $display("FAIL clr_mid_crc got %h want ffff", crc); end
    repeat (10) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || crc_rdy !== 1'b0) begin n_err++; $display("FAIL clr_mid_discard busy=%b rdy=%b want 0/0", busy, crc_rdy); end
    msg.push_back(8'($urandom));
    msg.push_back(8'($urandom));
    exp = crc_ref(msg);
    send_msg(msg, rp, cs);
    n_cmp++; if (cs !== exp) begin n_err++; $display("FAIL clr_mid_next got %h want %h", cs, exp); end
    clear_pulse();
  endtask

  task automatic test_rst_mid_shift();
    accept(8'($urandom), 1'b0);
    d_rdy = 1'b1;
    @(negedge clk);
    d_rdy = 1'b0;
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre_ovf got %b want 1", ovf); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    n_cmp++; if (crc !== 16'hFFFF) begin n_err++; $display("FAIL rst_mid_crc got %h want ffff", crc); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_mid_ovf got %b want 0", ovf); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_collision();
    d = 8'h5A; d_rdy = 1'b1; crc_n_rst = 1'b0;
    @(negedge clk);
    d_rdy = 1'b0; crc_n_rst = 1'b1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL coll_busy got %b want 0", busy); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL coll_ovf got %b want 0", ovf); end
    // d_last on its own must be ignored.
    d_last = 1'b1;
    repeat (3) @(negedge clk);
    d_last = 1'b0;
    n_cmp++; if (busy !== 1'b0 || crc_rdy !== 1'b0) begin n_err++; $display("FAIL dlast_alone busy=%b rdy=%b want 0/0", busy, crc_rdy); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_zero();
    test_check_string();
    test_random();
    test_overflow();
    test_clear_mid_shift();
    test_rst_mid_shift();
    test_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
